// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
//   Shared definitions for the multicycle CPU datapath blocks.
//   - MDU_WIDTH   : operand/result width of the multiply/divide unit
//   - mdu_state_t : multiply/divide unit FSM states
// ---------------------------------------------------------------------------
package cpu_pkg;

   localparam int unsigned MDU_WIDTH = 32;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_MULT   = 2'd1,
      ST_DIV    = 2'd2,
      ST_FINISH = 2'd3
   } mdu_state_t;

endpackage

// File: rtl/booth_step.sv
// ---------------------------------------------------------------------------
// booth_step
//   One radix-2 Booth iteration: conditional add/subtract of the multiplicand
//   into the upper half of the {A,Q,q-1} accumulator, then arithmetic shift
//   right by one.
// Ports
//   i_acc   [2W:0]  current accumulator {A[W-1:0], Q[W-1:0], q-1}
//   i_mcand [W-1:0] signed multiplicand
//   o_acc   [2W:0]  accumulator after this iteration
// ---------------------------------------------------------------------------
module booth_step
   import cpu_pkg::*;
#(
   parameter int unsigned WIDTH = MDU_WIDTH
) (
   input  logic [2*WIDTH:0] i_acc,
   input  logic [WIDTH-1:0] i_mcand,
   output logic [2*WIDTH:0] o_acc
);

   logic [WIDTH:0] w_a_ext;
   logic [WIDTH:0] w_m_ext;
   logic [WIDTH:0] w_sum;

   // The add/sub is done one bit wider so that the bit shifted into A carries
   // the true sign even when A +/- M overflows W bits (multiplicand = -2^(W-1)).
   always_comb begin
      w_a_ext = {i_acc[2*WIDTH], i_acc[2*WIDTH:WIDTH+1]};
      w_m_ext = {i_mcand[WIDTH-1], i_mcand};
      case (i_acc[1:0])
         2'b01:   w_sum = w_a_ext + w_m_ext;
         2'b10:   w_sum = w_a_ext - w_m_ext;
         default: w_sum = w_a_ext;
      endcase
      o_acc = {w_sum, i_acc[WIDTH:1]};
   end

endmodule

// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
//   Sequential signed multiply/divide unit. MULT uses radix-2 Booth, DIV uses
//   restoring division on magnitudes followed by a sign fix. Each operation
//   takes WIDTH iterations plus one FINISH cycle; results land in HI/LO.
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   start_mult in   1-cycle request: signed a*b (wins over start_div)
//   start_div  in   1-cycle request: signed a/b
//   a, b       in   operands, sampled only on the accepted start edge
//   hi         out  MULT: product high word; DIV: remainder
//   lo         out  MULT: product low word;  DIV: quotient
//   busy       out  operation in progress
//   done       out  1-cycle pulse, hi/lo just updated
//   div_zero   out  1-cycle pulse, DIV requested with b == 0
// ---------------------------------------------------------------------------
module mult_div_unit
   import cpu_pkg::*;
#(
   parameter int unsigned WIDTH = MDU_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_mult,
   input  logic             start_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             div_zero
);

   localparam int unsigned   CW   = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   mdu_state_t       r_state;
   mdu_state_t       w_state_nxt;
   logic [CW-1:0]    r_cnt;
   // Shared accumulator: MULT {A,Q,q-1}; DIV {remainder, quotient, unused 0}
   logic [2*WIDTH:0] r_acc;
   logic [WIDTH-1:0] r_opd;       // MULT: multiplicand; DIV: |divisor|
   logic             r_op_div;
   logic             r_neg_q;
   logic             r_neg_r;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic             r_busy;
   logic             r_done;
   logic             r_div_zero;

   logic             w_idle;
   logic             w_start_m;
   logic             w_start_d;
   logic             w_dz_req;
   logic             w_last;
   logic [WIDTH-1:0] w_a_mag;
   logic [WIDTH-1:0] w_b_mag;
   logic [2*WIDTH:0] w_booth_acc;
   logic [WIDTH:0]   w_rem_sh;
   logic [WIDTH:0]   w_diff;
   logic [2*WIDTH:0] w_div_acc;
   logic [WIDTH-1:0] w_quo_mag;
   logic [WIDTH-1:0] w_rem_mag;
   logic [WIDTH-1:0] w_quo_fix;
   logic [WIDTH-1:0] w_rem_fix;

   booth_step #(.WIDTH(WIDTH)) u_booth (
      .i_acc   (r_acc),
      .i_mcand (r_opd),
      .o_acc   (w_booth_acc)
   );

   always_comb begin
      w_idle    = (r_state == ST_IDLE);
      w_start_m = w_idle & start_mult;
      w_start_d = w_idle & ~start_mult & start_div & (b != '0);
      w_dz_req  = w_idle & ~start_mult & start_div & (b == '0);
      w_last    = (r_cnt == LAST);
      // Negating -2^(W-1) wraps back to 0x80..0, which is 2^(W-1) read unsigned.
      w_a_mag   = a[WIDTH-1] ? -a : a;
      w_b_mag   = b[WIDTH-1] ? -b : b;
   end

   // Restoring division step: shift {rem,quo} left, try subtracting |divisor|.
   always_comb begin
      w_rem_sh = {r_acc[2*WIDTH:WIDTH+1], r_acc[WIDTH]};
      w_diff   = w_rem_sh - {1'b0, r_opd};
      if (!w_diff[WIDTH]) begin
         w_div_acc = {w_diff[WIDTH-1:0], r_acc[WIDTH-1:1], 1'b1, 1'b0};
      end else begin
         w_div_acc = {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-1:1], 1'b0, 1'b0};
      end
   end

   always_comb begin
      w_quo_mag = r_acc[WIDTH:1];
      w_rem_mag = r_acc[2*WIDTH:WIDTH+1];
      w_quo_fix = r_neg_q ? -w_quo_mag : w_quo_mag;
      w_rem_fix = r_neg_r ? -w_rem_mag : w_rem_mag;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_start_m) begin
               w_state_nxt = ST_MULT;
            end else if (w_start_d) begin
               w_state_nxt = ST_DIV;
            end
         end
         ST_MULT, ST_DIV: begin
            if (w_last) begin
               w_state_nxt = ST_FINISH;
            end
         end
         ST_FINISH: w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt      <= '0;
         r_acc      <= '0;
         r_opd      <= '0;
         r_op_div   <= 1'b0;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
         r_hi       <= '0;
         r_lo       <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_div_zero <= 1'b0;
      end else begin
         r_busy     <= (w_state_nxt != ST_IDLE);
         r_done     <= (r_state == ST_FINISH);
         r_div_zero <= w_dz_req;
         case (r_state)
            ST_IDLE: begin
               r_cnt <= '0;
               if (w_start_m) begin
                  r_acc    <= {{WIDTH{1'b0}}, b, 1'b0};
                  r_opd    <= a;
                  r_op_div <= 1'b0;
               end else if (w_start_d) begin
                  r_acc    <= {{WIDTH{1'b0}}, w_a_mag, 1'b0};
                  r_opd    <= w_b_mag;
                  r_op_div <= 1'b1;
                  r_neg_q  <= a[WIDTH-1] ^ b[WIDTH-1];
                  r_neg_r  <= a[WIDTH-1];
               end
            end
            ST_MULT: begin
               r_acc <= w_booth_acc;
               r_cnt <= w_last ? '0 : r_cnt + CW'(1);
            end
            ST_DIV: begin
               r_acc <= w_div_acc;
               r_cnt <= w_last ? '0 : r_cnt + CW'(1);
            end
            ST_FINISH: begin
               if (r_op_div) begin
                  r_hi <= w_rem_fix;
                  r_lo <= w_quo_fix;
               end else begin
                  r_hi <= r_acc[2*WIDTH:WIDTH+1];
                  r_lo <= r_acc[WIDTH:1];
               end
            end
            default: r_cnt <= '0;
         endcase
      end
   end

   assign hi       = r_hi;
   assign lo       = r_lo;
   assign busy     = r_busy;
   assign done     = r_done;
   assign div_zero = r_div_zero;

endmodule

// File: tb/tb_mult_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_div_unit
//   Scoreboarded bench for mult_div_unit. Stimulus pushes the expected
//   result (from 64-bit integer arithmetic) into a queue; a monitor pops and
//   compares on every done / div_zero pulse.
// ---------------------------------------------------------------------------
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start_mult;
   logic        start_div;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        done;
   logic        div_zero;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit          is_dz;
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] m_hi;
   logic [31:0] m_lo;

   mult_div_unit #(.WIDTH(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .start_mult (start_mult),
      .start_div  (start_div),
      .a          (a),
      .b          (b),
      .hi         (hi),
      .lo         (lo),
      .busy       (busy),
      .done       (done),
      .div_zero   (div_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Reference: plain signed 64-bit arithmetic (division truncates toward 0,
   // remainder follows the dividend's sign).
   function automatic void model(input bit is_mult, input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] h, output logic [31:0] l);
      longint sx, sy, p, q, r;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      if (is_mult) begin
         p = sx * sy;
         h = p[63:32];
         l = p[31:0];
      end else begin
         q = sx / sy;
         r = sx % sy;
         h = r[31:0];
         l = q[31:0];
      end
   endfunction

   function automatic logic [31:0] rnd_opnd();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h7FFF_FFFF;
         4:       return 32'h0000_0001;
         default: return $urandom;
      endcase
   endfunction

   // Monitor: every result/exception pulse must match the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!reset && (done || div_zero)) begin
         if (sb.size() == 0) begin
            check("sb_nonempty", 64'({done, div_zero}), 64'd0);
         end else begin
            e = sb.pop_front();
            check("event_kind", 64'({done, div_zero}), e.is_dz ? 64'd1 : 64'd2);
            check(e.is_dz ? "held_hi" : "res_hi", 64'(hi), 64'(e.hi));
            check(e.is_dz ? "held_lo" : "res_lo", 64'(lo), 64'(e.lo));
         end
      end
   end

   // Issue one request at posedge+1 alignment and follow it for its full
   // lifetime. inject=1 fires a start pulse into edge 20 of the run.
   task automatic run_op(input bit m, input bit d, input logic [31:0] x, input logic [31:0] y,
                         input bit inject);
      exp_t e;
      int   done_at;
      bit   busy_ok;
      bit   is_dz;
      is_dz   = !m && d && (y == 32'd0);
      e.is_dz = is_dz;
      if (is_dz) begin
         e.hi = m_hi;
         e.lo = m_lo;
      end else begin
         model(m, x, y, e.hi, e.lo);
         m_hi = e.hi;
         m_lo = e.lo;
      end
      sb.push_back(e);
      start_mult = m;
      start_div  = d;
      a          = x;
      b          = y;
      @(posedge clk);
      #1;
      start_mult = 1'b0;
      start_div  = 1'b0;
      a          = $urandom;
      b          = $urandom;
      if (is_dz) begin
         check("dz_pulse", 64'(div_zero), 64'd1);
         check("dz_busy",  64'({busy, done}), 64'd0);
         @(posedge clk);
         #1;
         check("dz_one_cycle", 64'({div_zero, busy, done}), 64'd0);
         return;
      end
      busy_ok = (busy === 1'b1) && (done === 1'b0);
      done_at = -1;
      for (int k = 1; k <= 34; k++) begin
         @(posedge clk);
         #1;
         if (inject && k == 20) begin
            start_mult = 1'b0;
            start_div  = 1'b0;
         end
         if (k <= 32 && (busy !== 1'b1 || done !== 1'b0)) busy_ok = 1'b0;
         if (done === 1'b1 && done_at < 0) done_at = k;
         if (k == 33) check("finish_busy_low", 64'(busy), 64'd0);
         if (k == 34) check("done_one_cycle", 64'(done), 64'd0);
         if (inject && k == 19) begin
            start_mult = $urandom_range(0, 1);
            start_div  = 1'b1;
            a          = rnd_opnd();
            b          = rnd_opnd();
         end
      end
      check("busy_window", 64'(busy_ok), 64'd1);
      check("done_edge", 64'(done_at), 64'd33);
   endtask

   initial begin
      reset      = 1'b1;
      start_mult = 1'b0;
      start_div  = 1'b0;
      a          = '0;
      b          = '0;
      m_hi       = '0;
      m_lo       = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_hilo", {hi, lo}, 64'd0);
      check("reset_flags", 64'({busy, done, div_zero}), 64'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 1'b0);
      check("t1_mult", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
      run_op(1'b1, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
      check("t2_mult", {hi, lo}, 64'h3FFF_FFFF_0000_0001);
      run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
      check("t3_div_neg_a", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      run_op(1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0);
      check("t3_div_neg_b", {hi, lo}, 64'h0000_0001_FFFF_FFFD);

      // 1628201331 * 805654952 = 0x12345678_12345678
      run_op(1'b1, 1'b0, 32'd1628201331, 32'd805654952, 1'b0);
      check("t4_setup", {hi, lo}, 64'h1234_5678_1234_5678);
      run_op(1'b0, 1'b1, $urandom, 32'd0, 1'b0);
      check("t4_held", {hi, lo}, 64'h1234_5678_1234_5678);

      run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      check("t5_div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);
      run_op(1'b1, 1'b1, 32'd12345, 32'hFFFF_FF00, 1'b0);
      run_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0);
      run_op(1'b0, 1'b1, 32'd5, 32'h8000_0000, 1'b0);

      // Reset landing in the middle of a MULT
      sb.push_back('{1'b0, 32'd0, 32'd0});
      start_mult = 1'b1;
      a          = 32'd99;
      b          = 32'd77;
      @(posedge clk);
      #1;
      start_mult = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      sb.delete();
      m_hi = '0;
      m_lo = '0;
      check("midrst_hilo", {hi, lo}, 64'd0);
      check("midrst_flags", 64'({busy, done, div_zero}), 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("post_rst_idle", 64'({busy, done}), 64'd0);

      run_op(1'b1, 1'b0, 32'hFFFF_FF85, 32'd1000, 1'b1);
      run_op(1'b0, 1'b1, 32'd1000000, 32'hFFFF_FFF3, 1'b1);
      run_op(1'b1, 1'b0, 32'd65537, 32'd65535, 1'b0);

      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 3))
            0, 1:    run_op(1'b1, $urandom_range(0, 1), rnd_opnd(), rnd_opnd(), 1'b0);
            default: run_op(1'b0, 1'b1, rnd_opnd(), rnd_opnd(), n[2]);
         endcase
      end

      repeat (3) @(posedge clk);
      #1;
      check("sb_drained", 64'(sb.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
